fpu8_op_sequencer: RTL
======================

Name: fpu8_op_sequencer

Overview:
Shares one 8-bit FP arithmetic core and its exception checker between two requesters. The block does four things: round-robin arbitration, operand capture, exception screening, and core start/completion sequencing with a timeout. It returns one tagged response per accepted request. It sits between the requester ports and the FPU_8 datapath (arithmetic core plus exception checker), which the top level wires to the CORE_* and EXC_* ports.

Parameters:
QNAN, 8'h7F, canonical NaN returned for exception, unsupported-op and timeout responses
TIMEOUT_CYCLES, 15, maximum WAIT cycles without CORE_DONE before abort (1..2^CNT_W-1)
CNT_W, 4, width of the timeout counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  synchronous, active-low reset
REQ0_VALID / REQ1_VALID  in  1  requester has an operation pending
REQ0_READY / REQ1_READY  out  1  grant; a transfer occurs when VALID && READY
REQ0_OP / REQ1_OP  in  2  FPU_PACK operation code
REQ0_A, REQ0_B / REQ1_A, REQ1_B  in  8  operands
EXC_OP  out  2  operation code to the exception checker
EXC_A, EXC_B  out  8  operands to the exception checker
EXC_FLAG  in  1  combinational exception result
CORE_START  out  1  one-cycle start pulse to the arithmetic core
CORE_OP  out  2  operation code to the core
CORE_A, CORE_B  out  8  operands to the core
CORE_DONE  in  1  core result valid (single cycle)
CORE_RESULT  in  8  core result
RSP_VALID  out  1  response available
RSP_READY  in  1  response consumer ready
RSP_ID  out  1  requester index (0/1)
RSP_RESULT  out  8  result
RSP_EXC  out  1  exception or unsupported op
RSP_TIMEOUT  out  1  core timed out

Behaviour:
- Reset (RST_N=0 at an edge):
  - State goes to IDLE; grant pointer LAST goes to 1, so REQ0 wins the first tie.
  - Timeout counter clears; all output registers clear to 0.
  - Mid-operation reset abandons the transaction with no response; a CORE_DONE arriving afterwards is ignored.
- States: IDLE, CHECK, EXEC, WAIT, RESP.
- IDLE:
  - READYx is combinational and is asserted only in IDLE, only for the granted requester.
  - Grant rule: if only one VALID is high, grant it. If both are high, grant the index != LAST.
  - On handshake: latch OP/A/B into operand registers and the index into ID; go to CHECK.
  - With no VALID, stay in IDLE.
- CHECK (exactly 1 cycle):
  - EXC_OP/EXC_A/EXC_B are driven from the operand registers and stay stable from CHECK to return to IDLE.
  - EXC_FLAG is sampled at the end of CHECK.
  - EXC_FLAG=1: go to RESP with RESULT=QNAN, EXC=1.
  - Otherwise, if OP is not one of _ADDITION/_SUBTRACTION/_MULTIPLICATION: go to RESP with RESULT=QNAN, EXC=1.
  - Otherwise: go to EXEC.
- EXEC (1 cycle):
  - CORE_START=1 for this cycle only.
  - CORE_OP/A/B come from the operand registers and stay stable through WAIT.
  - Counter clears; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - CORE_DONE=1: latch CORE_RESULT; set EXC=0, TIMEOUT=0; go to RESP.
  - Counter reaches TIMEOUT_CYCLES without DONE: RESULT=QNAN, TIMEOUT=1, EXC=0; go to RESP.
  - If DONE and the timeout coincide, DONE wins.
  - CORE_DONE in any state other than WAIT is ignored.
- RESP:
  - RSP_VALID=1; RSP_* stays stable until RSP_READY.
  - On RSP_READY: LAST <= ID, RSP_VALID drops the next cycle, go to IDLE.
  - No READYx is asserted while in RESP.
- Latency, with handshake in cycle 0:
  - Normal path: CORE_START in cycle 2. DONE in cycle 2+k (k>=1) gives RSP_VALID in cycle 3+k.
  - Exception path: RSP_VALID in cycle 2, with no CORE_START.
- Throughput: at most one operation in flight. The next grant can occur in the cycle after RSP_READY is accepted.

Test Plan:
- Normal operation:
  - Stimulus: REQ0 _ADDITION A=8'h38 B=8'h38; EXC_FLAG=0; core raises DONE 2 cycles after START with 8'h40.
  - Response: START in cycle 2; RSP_VALID in cycle 5; RESULT=8'h40, ID=0, EXC=0, TIMEOUT=0.
- Exception path:
  - Stimulus: REQ1 _ADDITION with EXC_FLAG=1 in CHECK.
  - Response: no CORE_START; RSP_VALID in cycle 2; RESULT=8'h7F, ID=1, EXC=1.
- Unsupported op:
  - Stimulus: REQ0 OP=2'b11 with EXC_FLAG=0.
  - Response: no CORE_START; RESULT=8'h7F, EXC=1.
- Arbitration:
  - Stimulus: both VALIDs held high, RSP_READY=1, core DONE after 1 cycle, 4 transactions.
  - Response: grants 0,1,0,1; each READY is high for one cycle only, in IDLE.
- Timeout:
  - Stimulus: core never raises DONE; a late DONE is pulsed after the timeout.
  - Response: RESP after 15 WAIT cycles with RESULT=8'h7F, TIMEOUT=1; the late DONE is ignored.
- Backpressure and reset:
  - Stimulus: RSP_READY held low 10 cycles; then, in a separate transaction, RST_N=0 during WAIT followed by DONE.
  - Response: RSP_* is stable and no READYx is asserted while RSP_READY is low. After the reset, all outputs are 0, state is IDLE, and no response is produced.

Source files
------------

// File: rtl/fpu8_op_sequencer.sv
// Two-requester front end for a shared 8-bit FP core: round-robin grant, operand
// capture, exception screening, core start/done sequencing with timeout, tagged response.
module fpu8_op_sequencer #(
  parameter logic [7:0] QNAN           = 8'h7F,
  parameter int         TIMEOUT_CYCLES = 15,
  parameter int         CNT_W          = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0_valid,
  output logic       o_req0_ready,
  input  logic [1:0] i_req0_op,
  input  logic [7:0] i_req0_a,
  input  logic [7:0] i_req0_b,
  input  logic       i_req1_valid,
  output logic       o_req1_ready,
  input  logic [1:0] i_req1_op,
  input  logic [7:0] i_req1_a,
  input  logic [7:0] i_req1_b,
  output logic [1:0] o_exc_op,
  output logic [7:0] o_exc_a,
  output logic [7:0] o_exc_b,
  input  logic       i_exc_flag,
  output logic       o_core_start,
  output logic [1:0] o_core_op,
  output logic [7:0] o_core_a,
  output logic [7:0] o_core_b,
  input  logic       i_core_done,
  input  logic [7:0] i_core_result,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic       o_rsp_id,
  output logic [7:0] o_rsp_result,
  output logic       o_rsp_exc,
  output logic       o_rsp_timeout
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EXEC, S_WAIT, S_RESP} state_t;

  state_t r_state, w_next;

  logic [1:0]            w_req_valid;
  logic [1:0][1:0]       w_req_op;
  logic [1:0][7:0]       w_req_a, w_req_b;
  logic                  w_grant_vld, w_grant_id, w_hs, w_op_ok, w_reject, w_timeout;

  logic [1:0]            r_op;
  logic [7:0]            r_a, r_b;
  logic                  r_id, r_last;
  logic [CNT_W-1:0]      r_cnt;
  logic [7:0]            r_rsp_result;
  logic                  r_rsp_exc, r_rsp_timeout;

  assign w_req_valid = {i_req1_valid, i_req0_valid};
  assign w_req_op    = {i_req1_op, i_req0_op};
  assign w_req_a     = {i_req1_a, i_req0_a};
  assign w_req_b     = {i_req1_b, i_req0_b};

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_grant_vld = |w_req_valid;
    w_grant_id  = 1'b0;
    if (&w_req_valid)        w_grant_id = ~r_last;
    else if (w_req_valid[1]) w_grant_id = 1'b1;
  end

  assign w_hs      = (r_state == S_IDLE) && w_grant_vld;
  assign w_op_ok   = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_MUL);
  assign w_reject  = i_exc_flag || !w_op_ok;
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_next = S_CHECK;
      S_CHECK: w_next = w_reject ? S_RESP : S_EXEC;
      S_EXEC:  w_next = S_WAIT;
      S_WAIT:  if (i_core_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_core_start = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req0_ready = w_grant_vld && !w_grant_id;
        o_req1_ready = w_grant_vld &&  w_grant_id;
      end
      S_EXEC:  o_core_start = 1'b1;
      S_RESP:  o_rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  // Operand, response and arbitration state; a mid-operation reset drops everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_id          <= 1'b0;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_rsp_result  <= '0;
      r_rsp_exc     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_hs) begin
        r_op <= w_req_op[w_grant_id];
        r_a  <= w_req_a[w_grant_id];
        r_b  <= w_req_b[w_grant_id];
        r_id <= w_grant_id;
      end
      case (r_state)
        S_CHECK: if (w_reject) begin
          r_rsp_result  <= QNAN;
          r_rsp_exc     <= 1'b1;
          r_rsp_timeout <= 1'b0;
        end
        S_EXEC: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A done landing on the final wait cycle still wins over the timeout.
          if (i_core_done) begin
            r_rsp_result  <= i_core_result;
            r_rsp_exc     <= 1'b0;
            r_rsp_timeout <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_result  <= QNAN;
            r_rsp_exc     <= 1'b0;
            r_rsp_timeout <= 1'b1;
          end
        end
        S_RESP: if (i_rsp_ready) r_last <= r_id;
        default: ;
      endcase
    end
  end

  assign o_exc_op      = r_op;
  assign o_exc_a       = r_a;
  assign o_exc_b       = r_b;
  assign o_core_op     = r_op;
  assign o_core_a      = r_a;
  assign o_core_b      = r_b;
  assign o_rsp_id      = r_id;
  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_exc     = r_rsp_exc;
  assign o_rsp_timeout = r_rsp_timeout;

endmodule
